// File: rtl/devision_seq_param.sv
// Parametrised restoring divider: one quotient bit per clock, divide-by-zero flag, busy/done.
// Optional signed mode is compiled in with the SIGNED_EN macro (adds the sign port and the FIX state).
module devision_seq_param #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SIGNED_EN
    input  logic             sign,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_bz;

    logic             w_accept;
    logic             w_busy_nxt;
    logic             w_fix_req;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_rem_nxt;

`ifdef SIGNED_EN
    logic r_sgn;
    logic r_neg_q;
    logic r_neg_r;
    assign w_a_neg   = sign & a[WIDTH-1];
    assign w_b_neg   = sign & b[WIDTH-1];
    assign w_fix_req = r_sgn;
`else
    assign w_a_neg   = 1'b0;
    assign w_b_neg   = 1'b0;
    assign w_fix_req = 1'b0;
`endif

    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Remainder is widened by one bit before the compare so the shifted value never overflows.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_sub     = w_shift - {1'b0, r_div};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_busy_nxt  = (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                // A zero divisor spends one cycle in CALC so done still lands one edge after start.
                if (r_bz) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CW'(1)) begin
                    w_state_nxt = w_fix_req ? S_FIX : S_DONE;
                end
            end
            S_FIX:   w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
            y         <= '0;
            remainder <= '0;
            r_a       <= '0;
            r_div     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_bz      <= 1'b0;
`ifdef SIGNED_EN
            r_sgn     <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            busy <= w_busy_nxt;
            done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a   <= a;
                r_bz  <= (b == '0);
                r_div <= w_b_mag;
                r_quo <= w_a_mag;
                r_rem <= '0;
                r_cnt <= CW'(WIDTH);
                dz    <= 1'b0;
`ifdef SIGNED_EN
                r_sgn   <= sign;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
`endif
            end else if (r_state == S_CALC) begin
                if (r_bz) begin
                    y         <= '1;
                    remainder <= r_a;
                    dz        <= 1'b1;
                end else begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_state_nxt == S_DONE) begin
                        y         <= w_quo_nxt;
                        remainder <= w_rem_nxt;
                    end
                end
            end
`ifdef SIGNED_EN
            else if (r_state == S_FIX) begin
                // Truncation toward zero: remainder follows the dividend's sign.
                y         <= r_neg_q ? -r_quo : r_quo;
                remainder <= r_neg_r ? -r_rem : r_rem;
            end
`endif
        end
    end

endmodule

// File: tb/tb_devision_seq_param.sv
// Directed testbench for devision_seq_param (WIDTH=16); signed vectors run only when SIGNED_EN is defined.
module tb_devision_seq_param;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sign;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic [W-1:0] remainder;
  logic         dz;
  logic [1:0]   dbg_state;

  int n_checks;
  int n_errors;
  int lat;

  devision_seq_param #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef SIGNED_EN
    .sign       (sign),
`endif
    .busy       (busy),
    .done       (done),
    .y          (y),
    .remainder  (remainder),
    .dz         (dz),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // driver: present operands at a falling edge, start is accepted on the next rising edge
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    @(negedge clk);
    a     = va;
    b     = vb;
    sign  = vs;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // counts rising edges after the accepting edge until done is seen
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vs, input int exp_lat, input logic [W-1:0] exp_y,
                         input logic [W-1:0] exp_r, input logic exp_dz);
    launch(va, vb, vs);
    check({tag, "_busy_after_start"}, busy, 1'b1);
    check({tag, "_done_after_start"}, done, 1'b0);
    wait_done(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_y"}, y, exp_y);
    check({tag, "_rem"}, remainder, exp_r);
    check({tag, "_dz"}, dz, exp_dz);
    check({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sign  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_dz", dz, 1'b0);
    check("reset_y", y, 16'd0);
    check("reset_rem", remainder, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("d110_25", 16'd110, 16'd25, 1'b0, 16, 16'd4, 16'd10, 1'b0);
    run_div("d32200_37", 16'd32200, 16'd37, 1'b0, 16, 16'd870, 16'd10, 1'b0);
    run_div("d1234_56", 16'd1234, 16'd56, 1'b0, 16, 16'd22, 16'd2, 1'b0);
    run_div("dz77", 16'd77, 16'd0, 1'b0, 1, 16'hFFFF, 16'd77, 1'b1);
    run_div("d9_3", 16'd9, 16'd3, 1'b0, 16, 16'd3, 16'd0, 1'b0);
    run_div("dmax_1", 16'hFFFF, 16'd1, 1'b0, 16, 16'hFFFF, 16'd0, 1'b0);
    run_div("d5_9", 16'd5, 16'd9, 1'b0, 16, 16'd0, 16'd5, 1'b0);
    run_div("dmax_max", 16'hFFFF, 16'hFFFF, 1'b0, 16, 16'd1, 16'd0, 1'b0);
    run_div("d9_3b", 16'd9, 16'd3, 1'b0, 16, 16'd3, 16'd0, 1'b0);

    // start during CALC is ignored and the original result arrives on schedule
    launch(16'd1000, 16'd10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ign_y_hidden", y, 16'd3);
    @(negedge clk);
    a     = 16'd5;
    b     = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_still_busy", busy, 1'b1);
    wait_done(lat);
    check("ign_latency", lat + 5, 16);
    check("ign_y", y, 16'd100);
    check("ign_rem", remainder, 16'd0);

    // asynchronous reset mid-division
    launch(16'd500, 16'd3, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_dz", dz, 1'b0);
    check("arst_y", y, 16'd0);
    check("arst_rem", remainder, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("d100_7", 16'd100, 16'd7, 1'b0, 16, 16'd14, 16'd2, 1'b0);

`ifdef SIGNED_EN
    run_div("s_m7_2", 16'hFFF9, 16'd2, 1'b1, 17, 16'hFFFD, 16'hFFFF, 1'b0);
    run_div("s_ovf", 16'h8000, 16'hFFFF, 1'b1, 17, 16'h8000, 16'd0, 1'b0);
    run_div("s_7_m2", 16'd7, 16'hFFFE, 1'b1, 17, 16'hFFFD, 16'd1, 1'b0);
    run_div("u_110_25", 16'd110, 16'd25, 1'b0, 16, 16'd4, 16'd10, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
